// File: rtl/sync_fifo_ctrl_if.sv
// Stream-side bundle of the FIFO controller: write handshake, read handshake and fill level.
// The controller connects through the slave view; the producer/consumer side uses master.
interface sync_fifo_ctrl_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int LB_RAM_DEPTH = 8
);
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [LB_RAM_DEPTH:0]   level;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, level
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, level
    );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Valid/ready FIFO controller driving a registered-input dual-port RAM (port 0 write, port 1 read).
// A 2-entry output buffer hides the RAM read latency so both sides sustain one word per cycle.
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int RAM_DEPTH    = 256,
    parameter int LB_RAM_DEPTH = $clog2(RAM_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    sync_fifo_ctrl_if.slave         bus,
    output logic [DATA_WIDTH-1:0]   ram_din0,
    output logic [LB_RAM_DEPTH-1:0] ram_addr0,
    output logic                    ram_wr_en0,
    output logic [DATA_WIDTH-1:0]   ram_din1,
    output logic [LB_RAM_DEPTH-1:0] ram_addr1,
    output logic                    ram_wr_en1,
    input  logic [DATA_WIDTH-1:0]   ram_dout1
);
    localparam int CW = LB_RAM_DEPTH + 1;
    localparam logic [CW-1:0] RAM_FULL = CW'(RAM_DEPTH);

    logic [LB_RAM_DEPTH-1:0] wr_ptr;
    logic [LB_RAM_DEPTH-1:0] rd_ptr;
    logic [CW-1:0]           ram_count;
    logic [CW-1:0]           ram_count_nxt;
    logic                    inflight;
    logic [1:0]              buf_cnt;
    logic [1:0]              buf_cnt_nxt;
    logic [1:0]              buf_rem;
    logic [DATA_WIDTH-1:0]   buf0;
    logic [DATA_WIDTH-1:0]   buf1;
    logic [DATA_WIDTH-1:0]   buf0_nxt;
    logic [DATA_WIDTH-1:0]   buf1_nxt;
    logic [CW-1:0]           level_q;
    logic                    push;
    logic                    pop;
    logic                    issue;

    assign bus.in_ready  = !rst && (ram_count != RAM_FULL);
    assign bus.out_valid = (buf_cnt != 2'd0);
    assign bus.out_data  = buf0;
    assign bus.level     = level_q;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    // A read may be issued only if its word will find a free buffer slot on arrival;
    // ram_count is the registered count, so a word pushed this cycle is not yet readable.
    assign issue = (ram_count != '0) &&
                   ((buf_cnt + {1'b0, inflight}) < (2'd2 + {1'b0, pop}));

    assign ram_din0   = bus.in_data;
    assign ram_addr0  = wr_ptr;
    assign ram_wr_en0 = push;
    assign ram_din1   = '0;
    assign ram_addr1  = rd_ptr;
    assign ram_wr_en1 = 1'b0;

    always_comb begin
        buf_rem  = buf_cnt - {1'b0, pop};
        buf0_nxt = pop ? buf1 : buf0;
        buf1_nxt = buf1;
        if (inflight) begin
            if (buf_rem == 2'd0) begin
                buf0_nxt = ram_dout1;
            end else begin
                buf1_nxt = ram_dout1;
            end
        end
        buf_cnt_nxt   = buf_rem + {1'b0, inflight};
        ram_count_nxt = ram_count + CW'(push) - CW'(issue);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_count <= '0;
            inflight  <= 1'b0;
            buf_cnt   <= 2'd0;
            buf0      <= '0;
            buf1      <= '0;
            level_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + LB_RAM_DEPTH'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + LB_RAM_DEPTH'(1);
            end
            ram_count <= ram_count_nxt;
            inflight  <= issue;
            buf_cnt   <= buf_cnt_nxt;
            buf0      <= buf0_nxt;
            buf1      <= buf1_nxt;
            level_q   <= ram_count_nxt + CW'(issue) + CW'(buf_cnt_nxt);
        end
    end
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl with a registered-input dual-port RAM model attached.
// Words are queued when accepted and compared in order when the consumer pops them.
module tb_sync_fifo_ctrl;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LB    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [DW-1:0] ram_din0;
    logic [DW-1:0] ram_din1;
    logic [DW-1:0] ram_dout1;
    logic [LB-1:0] ram_addr0;
    logic [LB-1:0] ram_addr1;
    logic          ram_wr_en0;
    logic          ram_wr_en1;

    sync_fifo_ctrl_if #(.DATA_WIDTH(DW), .LB_RAM_DEPTH(LB)) bus ();

    sync_fifo_ctrl #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .LB_RAM_DEPTH(LB)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .ram_din0   (ram_din0),
        .ram_addr0  (ram_addr0),
        .ram_wr_en0 (ram_wr_en0),
        .ram_din1   (ram_din1),
        .ram_addr1  (ram_addr1),
        .ram_wr_en1 (ram_wr_en1),
        .ram_dout1  (ram_dout1)
    );

    // Registered-input RAM: write and read address register on the same edge, read is write-first.
    logic [DW-1:0] mem [DEPTH];
    logic [LB-1:0] addr1_q;
    always_ff @(posedge clk) begin
        if (ram_wr_en0) mem[ram_addr0] <= ram_din0;
        if (ram_wr_en1) mem[ram_addr1] <= ram_din1;
        addr1_q <= ram_addr1;
    end
    assign ram_dout1 = mem[addr1_q];

    int n_chk = 0;
    int n_err = 0;
    int model_cnt = 0;
    int n_wr = 0;
    int cyc = 0;
    logic [DW-1:0] sb[$];
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_od;
    logic          last_ov;
    logic          last_ir;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive at negedge, sample 1 time unit later, update the model.
    task automatic step(input logic r, input logic iv, input logic [DW-1:0] id, input logic ordy);
        logic          acc;
        logic          pp;
        logic [DW-1:0] exp_d;
        @(negedge clk);
        rst           = r;
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        #1;
        last_ov = bus.out_valid;
        last_ir = bus.in_ready;
        check("level", 32'(bus.level), model_cnt);
        if (prev_hold) begin
            check("hold_valid", 32'(bus.out_valid), 1);
            check("hold_data", 32'(bus.out_data), 32'(prev_od));
        end
        acc = iv & bus.in_ready;
        pp  = bus.out_valid & ordy;
        check("wr_en0", 32'(ram_wr_en0), 32'(acc));
        if (acc) begin
            check("addr0", 32'(ram_addr0), n_wr % DEPTH);
            check("din0", 32'(ram_din0), 32'(id));
            sb.push_back(id);
            n_wr++;
            model_cnt++;
        end
        if (pp) begin
            if (sb.size() == 0) begin
                check("pop_empty", 32'(bus.out_valid), 0);
            end else begin
                exp_d = sb.pop_front();
                check("data", 32'(bus.out_data), 32'(exp_d));
                model_cnt--;
            end
        end
        prev_hold = bus.out_valid & !ordy & !r;
        prev_od   = bus.out_data;
        if (r) begin
            sb.delete();
            model_cnt = 0;
            n_wr      = 0;
            prev_hold = 1'b0;
        end
        cyc++;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && sb.size() != 0; i++) step(1'b0, 1'b0, '0, 1'b1);
        check(tag, sb.size(), 0);
        step(1'b0, 1'b0, '0, 1'b1);
        check("empty_ov", 32'(last_ov), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // reset state
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 8'h3C, 1'b1);
        check("rst_ov", 32'(bus.out_valid), 0);
        check("rst_ir", 32'(bus.in_ready), 0);
        check("rst_level", 32'(bus.level), 0);
        check("rst_od", 32'(bus.out_data), 0);
        check("wr_en1", 32'(ram_wr_en1), 0);
        check("din1", 32'(ram_din1), 0);

        // single word into an empty FIFO: visible three cycles later
        step(1'b0, 1'b1, 8'hA5, 1'b1);
        check("t0_ir", 32'(last_ir), 1);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            check("lat_ov", 32'(last_ov), 32'(i == 3));
            if (i == 1) check("lat_level", 32'(bus.level), 1);
        end

        // fill to capacity with the consumer stalled
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 1'b1, 8'(i), 1'b0);
            check("fill_ir", 32'(last_ir), 1);
        end
        step(1'b0, 1'b1, 8'h77, 1'b0);
        check("full_ir", 32'(last_ir), 0);
        check("full_level", 32'(bus.level), 6);
        step(1'b0, 1'b0, '0, 1'b0);
        check("full_level2", 32'(bus.level), 6);

        // stream from full: no bubbles, pointers wrap several times
        d = 7;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 8'(d), 1'b1);
            if (last_ir) d++;
            check("stream_ov", 32'(last_ov), 1);
            if (i > 0) check("stream_ir", 32'(last_ir), 1);
        end
        drain("drain_stream");

        // random handshakes
        for (int i = 0; i < 2000; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        drain("drain_rand");

        // reset with a read in flight drops everything
        step(1'b0, 1'b1, 8'h31, 1'b0);
        step(1'b0, 1'b1, 8'h32, 1'b0);
        step(1'b0, 1'b1, 8'h33, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        check("mrst_ov", 32'(last_ov), 0);
        check("mrst_level", 32'(bus.level), 0);
        step(1'b0, 1'b1, 8'h55, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            check("fresh_ov", 32'(last_ov), 32'(i == 3));
        end

        // head stays stable while the consumer toggles ready
        step(1'b0, 1'b1, 8'hC1, 1'b0);
        step(1'b0, 1'b1, 8'hC2, 1'b0);
        step(1'b0, 1'b1, 8'hC3, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, ~i[0]);
        drain("drain_toggle");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
